alu_issue_stage: RTL and testbench

- ID/EX stage directly upstream of the execute ALU.
- Decodes one RV32I instruction word plus the register-file read data into the ALU's 4-bit op, operand A and operand B, and writeback control.
- Outputs are held in a single pipeline register with a valid/ready handshake, so the ALU sees stable combinational inputs for a full cycle.

---
 rtl/alu_issue_stage.sv | 194 +++++++++++++++++++
 tb/tb_alu_issue_stage.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_stage.sv
// ID/EX issue stage: decodes one RV32I word plus register read data into ALU controls, held in one handshaked register.
// Optional macro ALU_ISSUE_MUL_EN enables decode of MUL (OP, funct7=0000001, funct3=000).
module alu_issue_stage #(
    parameter int DATAWIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [31:0]          instr,
    input  logic [DATAWIDTH-1:0] pc,
    input  logic [DATAWIDTH-1:0] rs1_data,
    input  logic [DATAWIDTH-1:0] rs2_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [3:0]           alu_op,
    output logic [DATAWIDTH-1:0] alu_a,
    output logic [DATAWIDTH-1:0] alu_b,
    output logic [4:0]           rd_addr,
    output logic                 rd_we,
    output logic                 illegal,
    output logic [DATAWIDTH-1:0] pc_out
);

    localparam logic [3:0] OP_SLL  = 4'd0;
    localparam logic [3:0] OP_SRL  = 4'd1;
    localparam logic [3:0] OP_SRA  = 4'd2;
    localparam logic [3:0] OP_ADD  = 4'd3;
    localparam logic [3:0] OP_SUB  = 4'd4;
    localparam logic [3:0] OP_LUI  = 4'd5;
    localparam logic [3:0] OP_SLT  = 4'd6;
    localparam logic [3:0] OP_SLTU = 4'd7;
    localparam logic [3:0] OP_XOR  = 4'd8;
    localparam logic [3:0] OP_OR   = 4'd9;
    localparam logic [3:0] OP_AND  = 4'd10;
`ifdef ALU_ISSUE_MUL_EN
    localparam logic [3:0] OP_MUL  = 4'd11;
`endif

    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI   = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC = 7'b0010111;

    logic [6:0]           opcode_s;
    logic [2:0]           funct3_s;
    logic                 f7_zero_s;
    logic                 f7_alt_s;
    logic                 f7_mul_s;
    logic [DATAWIDTH-1:0] imm_i_s;
    logic [DATAWIDTH-1:0] imm_u_s;
    logic [DATAWIDTH-1:0] shamt_reg_s;
    logic [DATAWIDTH-1:0] shamt_imm_s;
    logic                 unused_s;

    logic [3:0]           raw_op_s;
    logic [DATAWIDTH-1:0] raw_a_s;
    logic [DATAWIDTH-1:0] raw_b_s;
    logic                 raw_ill_s;

    logic                 capture_s;

    logic                 valid_r;
    logic [3:0]           op_r;
    logic [DATAWIDTH-1:0] a_r;
    logic [DATAWIDTH-1:0] b_r;
    logic [4:0]           rd_r;
    logic                 we_r;
    logic                 ill_r;
    logic [DATAWIDTH-1:0] pc_r;

    assign opcode_s    = instr[6:0];
    assign funct3_s    = instr[14:12];
    assign f7_zero_s   = (instr[31:25] == 7'b0000000);
    assign f7_alt_s    = (instr[31:25] == 7'b0100000);
    assign f7_mul_s    = (instr[31:25] == 7'b0000001);
    assign imm_i_s     = {{(DATAWIDTH-12){instr[31]}}, instr[31:20]};
    assign imm_u_s     = {instr[31:12], 12'h000};
    assign shamt_reg_s = {{(DATAWIDTH-5){1'b0}}, rs2_data[4:0]};
    assign shamt_imm_s = {{(DATAWIDTH-5){1'b0}}, instr[24:20]};
    // rs1 field is resolved by the register file before this stage
    assign unused_s    = ^{instr[19:15], f7_mul_s};

    // Instruction decode into raw ALU controls before illegal-instruction masking
    always_comb begin
        raw_op_s  = OP_ADD;
        raw_a_s   = '0;
        raw_b_s   = '0;
        raw_ill_s = 1'b0;
        case (opcode_s)
            OPC_OP: begin
                raw_a_s = rs1_data;
                raw_b_s = rs2_data;
                case (funct3_s)
                    3'b000: begin
                        if (f7_zero_s) begin
                            raw_op_s = OP_ADD;
                        end else if (f7_alt_s) begin
                            raw_op_s = OP_SUB;
`ifdef ALU_ISSUE_MUL_EN
                        end else if (f7_mul_s) begin
                            raw_op_s = OP_MUL;
`endif
                        end else begin
                            raw_ill_s = 1'b1;
                        end
                    end
                    3'b001: begin raw_op_s = OP_SLL;  raw_b_s = shamt_reg_s; raw_ill_s = !f7_zero_s; end
                    3'b010: begin raw_op_s = OP_SLT;  raw_ill_s = !f7_zero_s; end
                    3'b011: begin raw_op_s = OP_SLTU; raw_ill_s = !f7_zero_s; end
                    3'b100: begin raw_op_s = OP_XOR;  raw_ill_s = !f7_zero_s; end
                    3'b101: begin
                        raw_b_s   = shamt_reg_s;
                        raw_op_s  = f7_alt_s ? OP_SRA : OP_SRL;
                        raw_ill_s = !(f7_zero_s || f7_alt_s);
                    end
                    3'b110: begin raw_op_s = OP_OR;   raw_ill_s = !f7_zero_s; end
                    3'b111: begin raw_op_s = OP_AND;  raw_ill_s = !f7_zero_s; end
                    default: raw_ill_s = 1'b1;
                endcase
            end
            OPC_OPIMM: begin
                raw_a_s = rs1_data;
                raw_b_s = imm_i_s;
                case (funct3_s)
                    3'b000: raw_op_s = OP_ADD;
                    3'b001: begin raw_op_s = OP_SLL; raw_b_s = shamt_imm_s; raw_ill_s = !f7_zero_s; end
                    3'b010: raw_op_s = OP_SLT;
                    3'b011: raw_op_s = OP_SLTU;
                    3'b100: raw_op_s = OP_XOR;
                    3'b101: begin
                        raw_b_s   = shamt_imm_s;
                        raw_op_s  = f7_alt_s ? OP_SRA : OP_SRL;
                        raw_ill_s = !(f7_zero_s || f7_alt_s);
                    end
                    3'b110: raw_op_s = OP_OR;
                    3'b111: raw_op_s = OP_AND;
                    default: raw_ill_s = 1'b1;
                endcase
            end
            OPC_LUI: begin
                raw_op_s = OP_LUI;
                raw_b_s  = imm_u_s;
            end
            OPC_AUIPC: begin
                raw_op_s = OP_ADD;
                raw_a_s  = pc;
                raw_b_s  = imm_u_s;
            end
            default: raw_ill_s = 1'b1;
        endcase
    end

    assign capture_s = in_valid && in_ready;
    assign in_ready  = !valid_r || out_ready;

    // Pipeline register: flush beats capture, capture beats drain; holds while stalled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_r <= 1'b0;
            op_r    <= OP_ADD;
            a_r     <= '0;
            b_r     <= '0;
            rd_r    <= 5'd0;
            we_r    <= 1'b0;
            ill_r   <= 1'b0;
            pc_r    <= '0;
        end else if (flush) begin
            valid_r <= 1'b0;
        end else if (capture_s) begin
            valid_r <= 1'b1;
            op_r    <= raw_ill_s ? OP_ADD : raw_op_s;
            a_r     <= raw_ill_s ? '0 : raw_a_s;
            b_r     <= raw_ill_s ? '0 : raw_b_s;
            rd_r    <= instr[11:7];
            we_r    <= !raw_ill_s && (instr[11:7] != 5'd0);
            ill_r   <= raw_ill_s;
            pc_r    <= pc;
        end else if (out_ready) begin
            valid_r <= 1'b0;
        end
    end

    assign out_valid = valid_r;
    assign alu_op    = op_r;
    assign alu_a     = a_r;
    assign alu_b     = b_r;
    assign rd_addr   = rd_r;
    assign rd_we     = we_r;
    assign illegal   = ill_r;
    assign pc_out    = pc_r;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Randomized + directed bench for alu_issue_stage against a queue-based reference model.
module tb_alu_issue_stage;

`ifdef ALU_ISSUE_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] instr, pc, rs1_data, rs2_data, alu_a, alu_b, pc_out;
    logic [3:0]  alu_op;
    logic [4:0]  rd_addr;
    logic        rd_we, illegal;

    always #5 clk = ~clk;

    alu_issue_stage #(.DATAWIDTH(32)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .instr(instr), .pc(pc), .rs1_data(rs1_data), .rs2_data(rs2_data),
        .out_valid(out_valid), .out_ready(out_ready), .alu_op(alu_op), .alu_a(alu_a),
        .alu_b(alu_b), .rd_addr(rd_addr), .rd_we(rd_we), .illegal(illegal), .pc_out(pc_out)
    );

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a, b, pc;
        logic [4:0]  rd;
        logic        we, ill, chk_ops;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
        end
    endtask

    // Reference decode written from the ISA rules: mnemonic table by funct3, then exceptions.
    function automatic exp_t ref_decode(input logic [31:0] ins, input logic [31:0] p,
                                        input logic [31:0] r1, input logic [31:0] r2);
        logic [3:0] by_f3 [8];
        exp_t e;
        logic [6:0] opc, f7;
        logic [2:0] f3;
        int op_i;
        by_f3 = '{4'd3, 4'd0, 4'd6, 4'd7, 4'd8, 4'd1, 4'd9, 4'd10};
        opc = ins[6:0]; f3 = ins[14:12]; f7 = ins[31:25];
        e.pc = p; e.rd = ins[11:7]; e.ill = 1'b0; e.chk_ops = 1'b1;
        e.op = 4'd3; e.a = 32'd0; e.b = 32'd0;
        if (opc == 7'h33) begin
            e.a = r1; e.b = r2;
            op_i = by_f3[f3];
            if (f7 == 7'h20 && f3 == 3'd0) e.op = 4'd4;
            else if (f7 == 7'h20 && f3 == 3'd5) e.op = 4'd2;
            else if (f7 == 7'h01 && f3 == 3'd0 && MUL_EN) e.op = 4'd11;
            else if (f7 == 7'h00) e.op = 4'(op_i);
            else e.ill = 1'b1;
            if (f3 == 3'd1 || f3 == 3'd5) e.b = r2 % 32;
        end else if (opc == 7'h13) begin
            e.a = r1; e.b = 32'($signed(ins[31:20]));
            e.op = by_f3[f3];
            if (f3 == 3'd1 || f3 == 3'd5) begin
                e.b = 32'(ins[24:20]);
                if (f3 == 3'd5 && f7 == 7'h20) e.op = 4'd2;
                else if (f7 != 7'h00) e.ill = 1'b1;
            end
        end else if (opc == 7'h37) begin
            e.op = 4'd5; e.b = ins & 32'hFFFFF000;
        end else if (opc == 7'h17) begin
            e.op = 4'd3; e.a = p; e.b = ins & 32'hFFFFF000;
        end else begin
            e.ill = 1'b1;
        end
        // op/a/b of an illegal entry are only defined for unknown opcodes
        if (e.ill) begin
            e.op = 4'd3; e.a = 32'd0; e.b = 32'd0;
            e.chk_ops = !(opc == 7'h33 || opc == 7'h13);
        end
        e.we = !e.ill && (e.rd != 5'd0);
        return e;
    endfunction

    task automatic check_outputs();
        exp_t e;
        check_val("out_valid", 32'(out_valid), 32'(q.size() != 0));
        if (q.size() != 0) begin
            e = q[0];
            check_val("illegal", 32'(illegal), 32'(e.ill));
            check_val("rd_we", 32'(rd_we), 32'(e.we));
            check_val("rd_addr", 32'(rd_addr), 32'(e.rd));
            check_val("pc_out", pc_out, e.pc);
            if (e.chk_ops) begin
                check_val("alu_op", 32'(alu_op), 32'(e.op));
                check_val("alu_a", alu_a, e.a);
                check_val("alu_b", alu_b, e.b);
            end
        end
    endtask

    // One cycle: check at negedge, drive, check in_ready, advance the model to the next edge.
    task automatic step(input logic iv, input logic [31:0] ins, input logic [31:0] p,
                        input logic [31:0] r1, input logic [31:0] r2,
                        input logic ordy, input logic fl);
        logic rdy;
        @(negedge clk);
        check_outputs();
        in_valid = iv; instr = ins; pc = p; rs1_data = r1; rs2_data = r2;
        out_ready = ordy; flush = fl;
        #1;
        rdy = (q.size() == 0) || ordy;
        check_val("in_ready", 32'(in_ready), 32'(rdy));
        if (fl) begin
            q.delete();
        end else begin
            if (q.size() != 0 && ordy) void'(q.pop_front());
            if (iv && rdy) q.push_back(ref_decode(ins, p, r1, r2));
        end
    endtask

    task automatic expect_now(input string tag, input logic [3:0] op,
                              input logic [31:0] a, input logic [31:0] b);
        @(posedge clk);
        #1;
        check_val({tag, ".valid"}, 32'(out_valid), 32'd1);
        check_val({tag, ".op"}, 32'(alu_op), 32'(op));
        check_val({tag, ".a"}, alu_a, a);
        check_val({tag, ".b"}, alu_b, b);
    endtask

    task automatic expect_flags(input string tag, input logic ill, input logic we);
        @(posedge clk);
        #1;
        check_val({tag, ".illegal"}, 32'(illegal), 32'(ill));
        check_val({tag, ".rd_we"}, 32'(rd_we), 32'(we));
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] ins;
        logic [6:0]  f7s [4];
        int k;
        f7s = '{7'h00, 7'h20, 7'h01, 7'h00};
        ins = $urandom;
        k = $urandom_range(0, 9);
        if (k <= 3) begin
            ins[6:0] = 7'h33;
            ins[31:25] = ($urandom_range(0, 7) == 0) ? 7'($urandom) : f7s[$urandom_range(0, 3)];
        end else if (k <= 6) begin
            ins[6:0] = 7'h13;
            if ($urandom_range(0, 3) != 0 && (ins[14:12] == 3'd1 || ins[14:12] == 3'd5))
                ins[31:25] = f7s[$urandom_range(0, 1)];
        end else if (k == 7) ins[6:0] = 7'h37;
        else if (k == 8) ins[6:0] = 7'h17;
        return ins;
    endfunction

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        instr = 32'd0; pc = 32'd0; rs1_data = 32'd0; rs2_data = 32'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_val("rst.valid", 32'(out_valid), 32'd0);
        check_val("rst.op", 32'(alu_op), 32'd3);
        check_val("rst.a", alu_a, 32'd0);
        check_val("rst.b", alu_b, 32'd0);
        check_val("rst.pc", pc_out, 32'd0);
        check_val("rst.rd", 32'(rd_addr), 32'd0);
        check_val("rst.we", 32'(rd_we), 32'd0);
        check_val("rst.ill", 32'(illegal), 32'd0);
        rst = 1'b0;

        step(1'b1, 32'h002081B3, 32'h0, 32'd5, 32'd7, 1'b1, 1'b0);
        expect_now("add", 4'd3, 32'd5, 32'd7);
        check_val("add.rd", 32'(rd_addr), 32'd3);
        check_val("add.we", 32'(rd_we), 32'd1);
        step(1'b1, 32'h402081B3, 32'h4, 32'd5, 32'd7, 1'b1, 1'b0);
        expect_now("sub", 4'd4, 32'd5, 32'd7);
        step(1'b1, 32'hFFF00293, 32'h8, 32'd0, 32'd9, 1'b1, 1'b0);
        expect_now("addi", 4'd3, 32'd0, 32'hFFFFFFFF);
        check_val("addi.rd", 32'(rd_addr), 32'd5);
        step(1'b1, 32'h4043D313, 32'hC, 32'h80000000, 32'd0, 1'b1, 1'b0);
        expect_now("srai", 4'd2, 32'h80000000, 32'd4);
        step(1'b1, 32'h002091B3, 32'h10, 32'd1, 32'h00000123, 1'b1, 1'b0);
        expect_now("sll", 4'd0, 32'd1, 32'd3);
        step(1'b1, 32'h123450B7, 32'h14, 32'd77, 32'd88, 1'b1, 1'b0);
        expect_now("lui", 4'd5, 32'd0, 32'h12345000);
        step(1'b1, 32'h12345097, 32'h100, 32'd77, 32'd88, 1'b1, 1'b0);
        expect_now("auipc", 4'd3, 32'h100, 32'h12345000);
        step(1'b1, 32'h022081B3, 32'h104, 32'd6, 32'd7, 1'b1, 1'b0);
        if (MUL_EN) begin
            expect_now("mul", 4'd11, 32'd6, 32'd7);
        end
        expect_flags("mul", !MUL_EN, MUL_EN);
        step(1'b1, 32'h0000007F, 32'h108, 32'd6, 32'd7, 1'b1, 1'b0);
        expect_now("badopc", 4'd3, 32'd0, 32'd0);
        expect_flags("badopc", 1'b1, 1'b0);

        // stall with a second instruction waiting, then release
        step(1'b1, 32'h002081B3, 32'h200, 32'd11, 32'd22, 1'b1, 1'b0);
        repeat (3) step(1'b1, 32'h0041C233, 32'h204, 32'd33, 32'd44, 1'b0, 1'b0);
        step(1'b1, 32'h0041C233, 32'h204, 32'd33, 32'd44, 1'b1, 1'b0);
        step(1'b0, 32'h0, 32'h0, 32'd0, 32'd0, 1'b1, 1'b0);
        step(1'b0, 32'h0, 32'h0, 32'd0, 32'd0, 1'b1, 1'b0);

        // flush beats a simultaneous capture
        step(1'b1, 32'h002081B3, 32'h300, 32'd1, 32'd2, 1'b1, 1'b1);
        @(posedge clk); #1;
        check_val("flush.valid", 32'(out_valid), 32'd0);

        // asynchronous reset in the middle of a stall
        step(1'b1, 32'h123450B7, 32'h400, 32'd0, 32'd0, 1'b0, 1'b0);
        step(1'b0, 32'h0, 32'h0, 32'd0, 32'd0, 1'b0, 1'b0);
        @(negedge clk);
        check_outputs();
        #2 rst = 1'b1;
        #1;
        check_val("arst.valid", 32'(out_valid), 32'd0);
        check_val("arst.op", 32'(alu_op), 32'd3);
        q.delete();
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 500; i++) begin
            step($urandom_range(0, 3) != 0, rand_instr(), $urandom, $urandom, $urandom,
                 $urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0);
        end
        step(1'b0, 32'h0, 32'h0, 32'd0, 32'd0, 1'b1, 1'b0);
        @(negedge clk);
        check_outputs();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
